hash_stream_core: RTL and testbench

- Parametrised successor to the byte-serial file hash top.
- Absorbs a byte stream between `start` and an end-of-file marker, then emits a digest of `8*DIGEST_BYTES` bits.
- Round count, digest width and IV are configurable.
- Additions over the previous generation:
  - message-length finalisation
  - digest valid/ack handshake
  - abort
  - back-to-back messages

---
 rtl/hash_stream_core.sv | 203 ++++++++++++++++++++
 tb/tb_hash_stream_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_stream_core.sv
// ---------------------------------------------------------------------------
// hash_stream_core
//
// Byte-serial streaming hash. A message is opened with `start`. Bytes then
// arrive over a ready/valid style link (f_dr from the source, f_rtr from the
// core), and the message is closed by a transfer carrying `eof`. Each
// absorbed byte is mixed into every state byte H[j] over ROUNDS round
// cycles. On EOF the message length is folded into H, and the result is
// presented on `digest` with `h_valid` until the consumer answers with
// `h_ack`.
//
// Parameters
//   DIGEST_BYTES : number of state/digest bytes (1..32); H[0] is digest LSB
//   ROUNDS       : round cycles per absorbed byte (1..16)
//   IV_BYTE      : initial value of every H[j] when a message starts
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-high, overrides everything
//   start    : open a new message (IDLE, or DONE together with h_ack)
//   abort    : drop the current message and return to IDLE
//   byte_in  : data byte, qualified by f_dr
//   f_dr     : source has a byte (or EOF) ready
//   eof      : marks the transfer as end-of-file (byte_in ignored)
//   f_rtr    : core ready to receive; transfer = f_dr && f_rtr
//   digest   : finalised hash, stable while h_valid is high
//   h_valid  : digest valid, held until h_ack
//   h_ack    : consumer accepts the digest
//   busy     : high in every state except IDLE
// ---------------------------------------------------------------------------
module hash_stream_core #(
    parameter int          DIGEST_BYTES = 4,
    parameter int          ROUNDS       = 4,
    parameter logic [7:0]  IV_BYTE      = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [7:0]                  byte_in,
    input  logic                        f_dr,
    input  logic                        eof,
    output logic                        f_rtr,
    output logic [8*DIGEST_BYTES-1:0]   digest,
    output logic                        h_valid,
    input  logic                        h_ack,
    output logic                        busy
);

    localparam int DW = 8 * DIGEST_BYTES;

    // The round counter is sized for the largest legal ROUNDS (16), so a
    // fixed 4-bit register covers every configuration, including ROUNDS=1.
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] h [DIGEST_BYTES];
    logic [7:0] b;
    logic [3:0] r;
    logic [DW-1:0] len;

    logic [7:0]    h_round [DIGEST_BYTES];
    logic [DW-1:0] h_final;

    // One round of mixing for a single state byte: xor in the absorbed byte,
    // rotate left by one, then add a constant that differs per round and per
    // byte position so that the state bytes do not stay identical.
    function automatic logic [7:0] mix_byte(
        input logic [7:0] hv,
        input logic [7:0] bv,
        input logic [3:0] rr,
        input int         j
    );
        logic [7:0] x;
        x = hv ^ bv;
        return {x[6:0], x[7]} + ({4'b0000, rr} ^ 8'(j));
    endfunction

    // Next value of every H[j] for the current round, all bytes in parallel.
    always_comb begin
        for (int j = 0; j < DIGEST_BYTES; j++) begin
            h_round[j] = mix_byte(h[j], b, r, j);
        end
    end

    // Finalised state: each H[j] xored with the matching byte of the length.
    always_comb begin
        h_final = '0;
        for (int j = 0; j < DIGEST_BYTES; j++) begin
            h_final[8*j +: 8] = h[j] ^ len[8*j +: 8];
        end
    end

    // Main FSM. f_rtr, h_valid and busy are registered alongside the state
    // they decode, so every transition below sets them for the state being
    // entered. abort is tested ahead of the per-state logic so that it wins
    // over start, h_ack and transfers in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            f_rtr   <= 1'b0;
            h_valid <= 1'b0;
            busy    <= 1'b0;
            digest  <= '0;
            len     <= '0;
            r       <= '0;
            b       <= '0;
            for (int j = 0; j < DIGEST_BYTES; j++) begin
                h[j] <= IV_BYTE;
            end
        end else if (abort && state != IDLE) begin
            // digest keeps its last value; H is reloaded by the next start.
            state   <= IDLE;
            f_rtr   <= 1'b0;
            h_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int j = 0; j < DIGEST_BYTES; j++) begin
                            h[j] <= IV_BYTE;
                        end
                        len   <= '0;
                        state <= WAIT_BYTE;
                        f_rtr <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    if (f_dr && f_rtr) begin
                        f_rtr <= 1'b0;
                        if (eof) begin
                            state <= FINAL;
                        end else begin
                            b     <= byte_in;
                            len   <= len + DW'(1);
                            r     <= '0;
                            state <= ROUND;
                        end
                    end
                end

                ROUND: begin
                    for (int j = 0; j < DIGEST_BYTES; j++) begin
                        h[j] <= h_round[j];
                    end
                    if (r == LAST_ROUND) begin
                        state <= WAIT_BYTE;
                        f_rtr <= 1'b1;
                    end else begin
                        r <= r + 4'd1;
                    end
                end

                FINAL: begin
                    for (int j = 0; j < DIGEST_BYTES; j++) begin
                        h[j] <= h_final[8*j +: 8];
                    end
                    digest  <= h_final;
                    state   <= DONE;
                    h_valid <= 1'b1;
                end

                DONE: begin
                    // start alone is ignored here; only start with h_ack
                    // chains straight into the next message.
                    if (h_ack) begin
                        h_valid <= 1'b0;
                        if (start) begin
                            for (int j = 0; j < DIGEST_BYTES; j++) begin
                                h[j] <= IV_BYTE;
                            end
                            len   <= '0;
                            state <= WAIT_BYTE;
                            f_rtr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    f_rtr   <= 1'b0;
                    h_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_stream_core.sv
// ---------------------------------------------------------------------------
// tb_hash_stream_core
//
// Directed bench for hash_stream_core. Two instances share the clock and the
// stream inputs but have separate start lines: dut_a uses the default
// parameters, dut_b uses ROUNDS=1, IV_BYTE=0 so that a single-byte digest
// can be worked out by hand. Only one instance is ever out of IDLE at a time,
// so the shared stream inputs do not disturb the idle one.
// ---------------------------------------------------------------------------
module tb_hash_stream_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        abort;
    logic [7:0]  byte_in;
    logic        f_dr;
    logic        eof;
    logic        h_ack;

    logic        f_rtr_a, h_valid_a, busy_a;
    logic [31:0] digest_a;
    logic        f_rtr_b, h_valid_b, busy_b;
    logic [31:0] digest_b;

    int n_checks = 0;
    int n_fail   = 0;
    int gap;

    logic [7:0] msg [8];

    hash_stream_core dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .abort   (abort),
        .byte_in (byte_in),
        .f_dr    (f_dr),
        .eof     (eof),
        .f_rtr   (f_rtr_a),
        .digest  (digest_a),
        .h_valid (h_valid_a),
        .h_ack   (h_ack),
        .busy    (busy_a)
    );

    hash_stream_core #(
        .DIGEST_BYTES (4),
        .ROUNDS       (1),
        .IV_BYTE      (8'h00)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .abort   (abort),
        .byte_in (byte_in),
        .f_dr    (f_dr),
        .eof     (eof),
        .f_rtr   (f_rtr_b),
        .digest  (digest_b),
        .h_valid (h_valid_b),
        .h_ack   (h_ack),
        .busy    (busy_b)
    );

    always #5 clk = ~clk;

    // Behavioural reference for a 4-byte digest: absorb n bytes, then fold
    // in the length.
    function automatic logic [31:0] model_hash(
        input logic [7:0] m [8],
        input int         n,
        input int         rounds,
        input logic [7:0] iv
    );
        logic [7:0] s [4];
        logic [7:0] x;
        logic [31:0] res;
        for (int j = 0; j < 4; j++) s[j] = iv;
        for (int i = 0; i < n; i++) begin
            for (int rr = 0; rr < rounds; rr++) begin
                for (int j = 0; j < 4; j++) begin
                    x    = s[j] ^ m[i];
                    s[j] = {x[6:0], x[7]} + 8'((rr ^ j) & 8'hFF);
                end
            end
        end
        res = 32'(n);
        for (int j = 0; j < 4; j++) res[8*j +: 8] = s[j] ^ res[8*j +: 8];
        return res;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [63:0] observed,
        input logic [63:0] expected
    );
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        abort   = 1'b0;
        byte_in = 8'h00;
        f_dr    = 1'b0;
        eof     = 1'b0;
        h_ack   = 1'b0;
        msg     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA0, 8'hFF, 8'h00};

        // Reset held for two cycles, then released.
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset_f_rtr",   64'(f_rtr_a),   64'd0);
        checkOutput("reset_h_valid", 64'(h_valid_a), 64'd0);
        checkOutput("reset_busy",    64'(busy_a),    64'd0);
        checkOutput("reset_digest",  64'(digest_a),  64'd0);

        // abort while IDLE has no effect.
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        applyStimulus();
        checkOutput("idle_abort_busy",  64'(busy_a),  64'd0);
        checkOutput("idle_abort_f_rtr", 64'(f_rtr_a), 64'd0);

        // Empty file on the default instance.
        start_a = 1'b1;
        applyStimulus();
        start_a = 1'b0;
        checkOutput("empty_f_rtr", 64'(f_rtr_a), 64'd1);
        checkOutput("empty_busy",  64'(busy_a),  64'd1);
        f_dr = 1'b1;
        eof  = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        eof  = 1'b0;
        checkOutput("empty_valid_lat1", 64'(h_valid_a), 64'd0);
        applyStimulus();
        checkOutput("empty_valid_lat2", 64'(h_valid_a), 64'd1);
        checkOutput("empty_digest",     64'(digest_a),  64'hA5A5A5A5);
        applyStimulus();
        checkOutput("empty_valid_held", 64'(h_valid_a), 64'd1);
        h_ack = 1'b1;
        applyStimulus();
        h_ack = 1'b0;
        checkOutput("empty_ack_valid", 64'(h_valid_a), 64'd0);
        checkOutput("empty_ack_busy",  64'(busy_a),    64'd0);

        // Single zero byte, ROUNDS=1, IV=0: H = {03,02,01,00}, len=1.
        start_b = 1'b1;
        applyStimulus();
        start_b = 1'b0;
        byte_in = 8'h00;
        f_dr    = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        checkOutput("one_f_rtr_low",  64'(f_rtr_b), 64'd0);
        applyStimulus();
        checkOutput("one_f_rtr_back", 64'(f_rtr_b), 64'd1);
        f_dr = 1'b1;
        eof  = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        eof  = 1'b0;
        applyStimulus();
        checkOutput("one_valid",  64'(h_valid_b), 64'd1);
        checkOutput("one_digest", 64'(digest_b),  64'h03020101);
        h_ack = 1'b1;
        applyStimulus();
        h_ack = 1'b0;
        checkOutput("one_idle", 64'(busy_b), 64'd0);

        // Throughput: 8 bytes with f_dr held high, one transfer per 5 cycles.
        start_a = 1'b1;
        applyStimulus();
        start_a = 1'b0;
        f_dr    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_in = msg[i];
            applyStimulus();
            gap = 0;
            while (f_rtr_a !== 1'b1 && gap < 20) begin
                applyStimulus();
                gap++;
            end
            checkOutput($sformatf("stream_gap_%0d", i), 64'(gap), 64'd4);
        end
        eof = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        eof  = 1'b0;
        applyStimulus();
        checkOutput("stream_valid",  64'(h_valid_a), 64'd1);
        checkOutput("stream_digest", 64'(digest_a),  64'(model_hash(msg, 8, 4, 8'hA5)));

        // Back-to-back: h_ack with start goes straight to WAIT_BYTE.
        h_ack   = 1'b1;
        start_a = 1'b1;
        applyStimulus();
        h_ack   = 1'b0;
        start_a = 1'b0;
        checkOutput("b2b_f_rtr",   64'(f_rtr_a),   64'd1);
        checkOutput("b2b_h_valid", 64'(h_valid_a), 64'd0);
        f_dr = 1'b1;
        eof  = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        eof  = 1'b0;
        applyStimulus();
        checkOutput("b2b_valid",  64'(h_valid_a), 64'd1);
        checkOutput("b2b_digest", 64'(digest_a),  64'hA5A5A5A5);
        h_ack = 1'b1;
        applyStimulus();
        h_ack = 1'b0;

        // abort during ROUND returns to IDLE, digest keeps its value.
        start_a = 1'b1;
        applyStimulus();
        start_a = 1'b0;
        byte_in = 8'h3C;
        f_dr    = 1'b1;
        applyStimulus();
        f_dr  = 1'b0;
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("abort_busy",   64'(busy_a),  64'd0);
        checkOutput("abort_f_rtr",  64'(f_rtr_a), 64'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("abort_no_valid", 64'(h_valid_a), 64'd0);
        checkOutput("abort_digest",   64'(digest_a),  64'hA5A5A5A5);

        // Reset while DONE clears h_valid and digest.
        start_a = 1'b1;
        applyStimulus();
        start_a = 1'b0;
        f_dr    = 1'b1;
        eof     = 1'b1;
        applyStimulus();
        f_dr = 1'b0;
        eof  = 1'b0;
        applyStimulus();
        checkOutput("rst_done_valid_pre", 64'(h_valid_a), 64'd1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst_done_valid",  64'(h_valid_a), 64'd0);
        checkOutput("rst_done_digest", 64'(digest_a),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
